// File: rtl/vector_loader.sv
// vector_loader: packs WORD-bit host words into Size-bit vectors for the URAM stage.
// Optional batch counter port enabled by defining LOADER_STATUS_EN.
module vector_loader #(
    parameter int Size      = 256,
    parameter int WORD      = 32,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 1,
    parameter int NUM_VEC   = 2,
    parameter int COOLDOWN  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD-1:0]   s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [Size-1:0]   wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_commit,
    output logic              en_read
`ifdef LOADER_STATUS_EN
    ,
    output logic [15:0]       batch_count
`endif
);

    localparam int LANES = Size / WORD;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int CW    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);
    localparam logic [SW-1:0]     LAST_SLOT = SW'(NUM_VEC - 1);
    localparam logic [CW-1:0]     CD_LOAD   = CW'(COOLDOWN - 1);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

    if (Size % WORD != 0) begin : g_bad_size
        $error("Size must be a multiple of WORD");
    end
    if (BASE_ADDR < 1 || BASE_ADDR + NUM_VEC > 32) begin : g_bad_addr
        $error("operand slots must lie in 1..31");
    end
    if (COOLDOWN < 1 || NUM_VEC < 1) begin : g_bad_cfg
        $error("COOLDOWN and NUM_VEC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [Size-1:0]   shadow_q, shadow_d;

    logic              s_ready_d;
    logic [Size-1:0]   wr_data_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              wr_commit_d;
    logic              en_read_d;

    logic accept;
    logic last_word;
    logic last_vec;

    assign accept    = s_valid && s_ready && (state_q == S_FILL);
    assign last_word = accept && (lane_q == LAST_LANE);
    assign last_vec  = last_word && (slot_q == LAST_SLOT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_FILL: begin
                if (last_vec) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_COOL;
                cnt_d   = CD_LOAD;
            end
            S_COOL: begin
                if (cnt_q == '0) begin
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Output values are computed here and registered below, so every
    // output changes only on a clock edge.
    always_comb begin
        lane_d      = lane_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        wr_data_d   = wr_data;
        wr_addr_d   = wr_addr;
        wr_commit_d = 1'b0;
        en_read_d   = (state_q == S_START);
        s_ready_d   = (state_d == S_FILL);

        if (accept) begin
            shadow_d[lane_q*WORD +: WORD] = s_data;
            lane_d = lane_q + 1'b1;
        end

        if (last_word) begin
            wr_data_d   = shadow_d;
            wr_addr_d   = BASE_A + ADDR_W'(slot_q);
            wr_commit_d = 1'b1;
            lane_d      = '0;
            slot_d      = last_vec ? '0 : slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q    <= '0;
            slot_q    <= '0;
            shadow_q  <= '0;
            s_ready   <= 1'b0;
            wr_data   <= '0;
            wr_addr   <= '0;
            wr_commit <= 1'b0;
            en_read   <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            slot_q    <= slot_d;
            shadow_q  <= shadow_d;
            s_ready   <= s_ready_d;
            wr_data   <= wr_data_d;
            wr_addr   <= wr_addr_d;
            wr_commit <= wr_commit_d;
            en_read   <= en_read_d;
        end
    end

`ifdef LOADER_STATUS_EN
    logic [15:0] batch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            batch_q <= '0;
        end else if (en_read_d && batch_q != 16'hFFFF) begin
            batch_q <= batch_q + 16'd1;
        end
    end

    assign batch_count = batch_q;
`endif

endmodule

// File: tb/tb_vector_loader.sv
// tb_vector_loader: randomized scoreboard bench for vector_loader.
// Expected vectors come from a word-list model; a monitor checks commits.
module tb_vector_loader;

    localparam int SZ    = 256;
    localparam int WD    = 32;
    localparam int AW    = 6;
    localparam int BASE  = 1;
    localparam int NV    = 2;
    localparam int CD    = 10;
    localparam int LANES = SZ / WD;

    logic          clk;
    logic          rst;
    logic [WD-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [SZ-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_commit;
    logic          en_read;
`ifdef LOADER_STATUS_EN
    logic [15:0]   batch_count;
`endif

    vector_loader #(
        .Size(SZ), .WORD(WD), .ADDR_W(AW),
        .BASE_ADDR(BASE), .NUM_VEC(NV), .COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .wr_data(wr_data),
        .wr_addr(wr_addr),
        .wr_commit(wr_commit),
        .en_read(en_read)
`ifdef LOADER_STATUS_EN
        ,
        .batch_count(batch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SZ-1:0] data;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    int            commit_cyc[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            en_count = 0;
    int            batches_exp = 0;

    // Reference model: a list of accepted words grouped into vectors.
    logic [SZ-1:0] m_vec;
    int            m_lanes = 0;
    int            m_slot  = 0;
    bit            tog     = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [SZ-1:0] act,
                       input logic [SZ-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_accept(input logic [WD-1:0] w);
        exp_t e;
        m_vec[m_lanes*WD +: WD] = w;
        m_lanes++;
        if (m_lanes == LANES) begin
            e.addr = AW'(BASE + m_slot);
            e.data = m_vec;
            e.last = (m_slot == NV - 1);
            exp_q.push_back(e);
            if (e.last) batches_exp++;
            m_lanes = 0;
            m_slot  = (m_slot + 1) % NV;
        end
    endtask

    // mode 0: continuous, 1: toggle every cycle, 2: random gaps
    task automatic push_word(input logic [WD-1:0] w, input int mode,
                             output int waits);
        int  guard;
        bit  done;
        guard = 0;
        done  = 0;
        waits = 0;
        while (!done) begin
            @(negedge clk);
            case (mode)
                1:       begin s_valid = tog; tog = ~tog; end
                2:       s_valid = ($urandom_range(0, 3) != 0);
                default: s_valid = 1'b1;
            endcase
            s_data = s_valid ? w : WD'($urandom);
            #4;
            if (s_valid && s_ready) begin
                model_accept(w);
                done = 1;
            end else begin
                waits++;
                guard++;
                if (guard > 200) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL accept_timeout: got no accept expected accept");
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = WD'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        m_lanes = 0;
        m_slot  = 0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_commit", wr_commit, 0);
        chk("rst_en_read", en_read, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", s_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", s_ready, 1);
    endtask

    // Monitor: pops expected vectors on commits and checks hold/en_read timing.
    logic [AW-1:0] cur_addr;
    logic [SZ-1:0] cur_data;
    bit            pend;
    bit            exp_en;
    bit            committed;
    exp_t          me;

    always @(negedge clk) begin
        if (!rst) begin
            cur_addr  = '0;
            cur_data  = '0;
            pend      = 0;
            committed = 0;
        end else begin
            exp_en = pend;
            pend   = 0;
            if (wr_commit) begin
                commit_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got addr %0d expected none",
                             wr_addr);
                end else begin
                    me = exp_q.pop_front();
                    chk("commit_addr", wr_addr, me.addr);
                    chk("commit_data", wr_data, me.data);
                    cur_addr  = me.addr;
                    cur_data  = me.data;
                    pend      = me.last;
                    committed = 1;
                end
            end else begin
                chk("hold_addr", wr_addr, cur_addr);
                chk("hold_data", wr_data, cur_data);
            end
            chk("en_read", en_read, exp_en);
            if (en_read) en_count++;
            if (committed) chk("addr_nonzero", (wr_addr != 0), 1);
        end
    end

    int waits;
    int d;

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_vec   = '0;
        repeat (3) @(negedge clk);
        chk("init_s_ready", s_ready, 0);
        chk("init_wr_data", wr_data, 0);
        chk("init_wr_addr", wr_addr, 0);
        chk("init_wr_commit", wr_commit, 0);
        chk("init_en_read", en_read, 0);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", s_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", s_ready, 1);

        for (int i = 1; i <= 16; i++) push_word(WD'(i), 0, waits);

        push_word(WD'(17), 0, waits);
        chk("cooldown_stall", waits, 1 + CD);
        for (int i = 18; i <= 32; i++) push_word(WD'(i), 0, waits);
        idle(2);

        commit_cyc.delete();
        tog = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(WD'(i), 1, waits);
        idle(3);
        chk("toggle_commits", commit_cyc.size(), 2);
        if (commit_cyc.size() == 2) begin
            d = commit_cyc[1] - commit_cyc[0];
            chk("toggle_spacing", d, 16);
        end

        for (int i = 0; i < 5; i++) push_word(WD'($urandom), 0, waits);
        do_reset();
        for (int i = 1; i <= 16; i++) push_word(WD'(i), 0, waits);

        for (int b = 0; b < 4 * NV * LANES; b++) begin
            push_word(WD'($urandom), 2, waits);
        end
        idle(CD + 6);
        chk("queue_drained", exp_q.size(), 0);
        chk("en_read_count", en_count, batches_exp);

`ifdef LOADER_STATUS_EN
        do_reset();
        chk("batch_count_rst", batch_count, 0);
        for (int b = 0; b < 3 * NV * LANES; b++) begin
            push_word(WD'($urandom), 2, waits);
        end
        idle(CD + 6);
        chk("batch_count_3", batch_count, 3);
        @(negedge clk);
        force dut.batch_q = 16'hFFFF;
        @(negedge clk);
        release dut.batch_q;
        for (int b = 0; b < NV * LANES; b++) begin
            push_word(WD'($urandom), 0, waits);
        end
        idle(CD + 6);
        chk("batch_count_sat", batch_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
